// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction memory controller.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;

endpackage

// File: rtl/imem_ctrl_byte_packer.sv
// Assembles a little-endian word from a stream of bytes, one lane per byte.
module imem_byte_packer #(
    parameter int LANES = 4,
    parameter int CNT_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [7:0]         i_byte,
    output logic [CNT_W-1:0]   o_cnt,
    output logic [LANES*8-1:0] o_word,
    output logic               o_word_done
);

    logic [LANES-1:0][7:0] r_lanes;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_last;
    logic [LANES-1:0][7:0] w_word;

    assign w_last      = (r_cnt == CNT_W'(LANES - 1));
    assign o_word_done = i_en & w_last;
    assign o_cnt       = r_cnt;
    assign o_word      = w_word;

    // Complete word includes the byte arriving this cycle so it can be written immediately
    always_comb begin
        w_word        = r_lanes;
        w_word[r_cnt] = i_byte;
    end

    // Lane capture and lane counter; clear wins so a load boundary always restarts at lane 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_lanes[r_cnt] <= i_byte;
            r_cnt          <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory controller: clears memory after reset, serves single-cycle
// fetches in RUN, and accepts a byte-serial program load in LOAD.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_fault,
    input  logic              load_start,
    input  logic              load_byte_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_done,
    output logic              load_busy,
    output logic              load_err,
    output logic [ADDR_W-2:0] load_words
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int IW    = ADDR_W - 2;
    localparam int PW    = ADDR_W - 1;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    imem_state_t       r_state;
    logic [IW-1:0]     r_clr_idx;
    logic [PW-1:0]     r_ptr;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_run;
    logic              w_load;
    logic              w_accept;
    logic              w_aligned;
    logic [IW-1:0]     w_fidx;
    logic              w_room;
    logic              w_byte_en;
    logic              w_pk_clr;
    logic              w_word_done;
    logic              w_partial;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] w_word;
    logic              w_we;
    logic [IW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_run     = (r_state == RUN);
    assign w_load    = (r_state == LOAD);
    assign w_accept  = fetch_req & w_run;
    assign w_fidx    = fetch_addr[ADDR_W-1:2];
    assign w_aligned = (fetch_addr[1:0] == 2'b00);
    // Pointer equals DEPTH once memory is full; further bytes are dropped, never wrapped
    assign w_room    = (r_ptr < PW'(DEPTH));
    assign w_byte_en = w_load & load_byte_valid & w_room;
    assign w_pk_clr  = (w_run & load_start) | (w_load & load_done);
    // Lane count after this cycle's byte is non-zero: the load ends on a partial word
    assign w_partial = w_byte_en ? ~w_word_done : (w_cnt != '0);

    assign fetch_ready = w_run;
    assign load_busy   = ~w_run;
    assign load_err    = r_err;
    assign load_words  = r_ptr;

    imem_byte_packer #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_pk_clr),
        .i_en        (w_byte_en),
        .i_byte      (load_byte),
        .o_cnt       (w_cnt),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // Single write port shared by the clear sweep and the byte packer
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_idx;
        w_wdata = '0;
        if (r_state == CLEAR) begin
            w_we = 1'b1;
        end else if (w_word_done) begin
            w_we    = 1'b1;
            w_waddr = r_ptr[IW-1:0];
            w_wdata = w_word;
        end
    end

    // Memory array has no reset; the clear sweep zeroes it
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    // Controller FSM: clear sweep, run, and load bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ptr     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_idx <= r_clr_idx + IW'(1);
                    if (r_clr_idx == IW'(DEPTH - 1))
                        r_state <= RUN;
                end
                RUN: begin
                    if (load_start) begin
                        r_state <= LOAD;
                        r_ptr   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_word_done)
                        r_ptr <= r_ptr + PW'(1);
                    if (load_byte_valid & ~w_room)
                        r_err <= 1'b1;
                    if (load_done) begin
                        r_state <= RUN;
                        if (w_partial)
                            r_err <= 1'b1;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    // Fetch response: asynchronous array read registered into the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_instr <= '0;
        end else begin
            fetch_valid <= w_accept;
            fetch_fault <= w_accept & ~w_aligned;
            fetch_instr <= (w_accept & w_aligned) ? r_mem[w_fidx] : '0;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized bench for imem_ctrl against a word-array reference model.
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [7:0]  fetch_addr = '0;
    logic        load_start = 1'b0;
    logic        load_byte_valid = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_done = 1'b0;
    logic        fetch_ready, fetch_valid, fetch_fault, load_busy, load_err;
    logic [31:0] fetch_instr;
    logic [6:0]  load_words;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_mem [64];
    int          m_words = 0;
    bit          m_err = 1'b0;
    logic [7:0]  q[$];

    imem_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ready     (fetch_ready),
        .fetch_valid     (fetch_valid),
        .fetch_instr     (fetch_instr),
        .fetch_fault     (fetch_fault),
        .load_start      (load_start),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .load_done       (load_done),
        .load_busy       (load_busy),
        .load_err        (load_err),
        .load_words      (load_words)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int w = 0; w < 64; w++) m_mem[w] = '0;
        m_words = 0;
        m_err   = 1'b0;
    endtask

    // Load effect from the byte list alone: whole words up to capacity land in order
    task automatic model_load();
        int n;
        int wn;
        n  = q.size();
        wn = n / 4;
        if (wn > 64) wn = 64;
        for (int w = 0; w < wn; w++)
            m_mem[w] = {q[4*w+3], q[4*w+2], q[4*w+1], q[4*w]};
        m_words = wn;
        m_err   = (n > 256) || (n % 4 != 0);
    endtask

    task automatic fill_rand(input int n);
        q.delete();
        repeat (n) q.push_back(8'($urandom));
    endtask

    task automatic fetch_one(input logic [7:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req = 1'b0;
        chk("f_vld", fetch_valid, 1);
        chk("f_fault", fetch_fault, (a[1:0] != 2'b00));
        chk("f_instr", fetch_instr, (a[1:0] == 2'b00) ? m_mem[a[7:2]] : 32'h0);
    endtask

    task automatic fetch_burst(input int n);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            fetch_one(a);
        end
        step();
        chk("f_idle", fetch_valid, 0);
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (!fetch_ready && cyc < 200) begin
            step();
            cyc++;
            if (cyc == 1) chk("clr_busy", load_busy, 1);
        end
        chk("clr_cycles", cyc, 64);
    endtask

    task automatic run_load(input bit do_start, input bit merge_done);
        if (do_start) begin
            load_start = 1'b1;
            step();
            load_start = 1'b0;
            chk("ld_busy", load_busy, 1);
            chk("ld_err_clr", load_err, 0);
            chk("ld_words_clr", load_words, 0);
        end
        foreach (q[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                fetch_req  = 1'($urandom_range(0, 1));
                fetch_addr = 8'($urandom);
                load_start = 1'($urandom_range(0, 1));
                step();
                load_start = 1'b0;
                chk("ld_nofetch", fetch_valid, 0);
            end
            fetch_req       = 1'b0;
            load_byte_valid = 1'b1;
            load_byte       = q[i];
            if (merge_done && i == q.size() - 1) load_done = 1'b1;
            step();
            load_byte_valid = 1'b0;
        end
        if (!(merge_done && q.size() > 0)) begin
            load_done = 1'b1;
            step();
        end
        load_done = 1'b0;
        model_load();
        chk("ld_ready", fetch_ready, 1);
        chk("ld_words", load_words, m_words);
        chk("ld_err", load_err, m_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_zero();
        repeat (3) step();
        chk("rst_vld", fetch_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_instr", fetch_instr, 0);
        chk("rst_err", load_err, 0);
        chk("rst_words", load_words, 0);
        chk("rst_busy", load_busy, 1);
        chk("rst_ready", fetch_ready, 0);

        // Fetch held high through the clear sweep
        fetch_req  = 1'b1;
        fetch_addr = 8'h00;
        rst_n      = 1'b1;
        wait_ready();
        step();
        fetch_req = 1'b0;
        chk("first_vld", fetch_valid, 1);
        chk("first_instr", fetch_instr, 32'h0);
        chk("first_fault", fetch_fault, 0);
        fetch_burst(20);

        // Two known instructions
        q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        run_load(1'b1, 1'b0);
        chk("two_words", load_words, 2);
        fetch_one(8'h04);
        chk("w1_const", fetch_instr, 32'h00200593);
        fetch_one(8'h06);
        chk("mis_instr", fetch_instr, 32'h0);
        chk("mis_fault", fetch_fault, 1);

        // Fetch and load_start on the same edge see pre-load contents
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 8'h04;
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        chk("co_vld", fetch_valid, 1);
        chk("co_instr", fetch_instr, 32'h00200593);
        chk("co_ready", fetch_ready, 0);
        fill_rand(12);
        run_load(1'b0, 1'b1);
        fetch_burst(10);

        // Random loads, whole and partial, with fetch sweeps between them
        repeat (6) begin
            fill_rand($urandom_range(0, 40));
            run_load(1'b1, 1'($urandom_range(0, 1)));
            fetch_burst(16);
        end

        // Load strobes outside LOAD are ignored
        load_byte_valid = 1'b1;
        load_byte       = 8'hAA;
        load_done       = 1'b1;
        step();
        load_byte_valid = 1'b0;
        load_done       = 1'b0;
        chk("run_ign_words", load_words, m_words);
        chk("run_ign_err", load_err, m_err);
        chk("run_ign_busy", load_busy, 0);

        // Six bytes: one word written, partial discarded
        fill_rand(8);
        run_load(1'b1, 1'b0);
        fill_rand(6);
        run_load(1'b1, 1'b0);
        chk("part_err", load_err, 1);
        chk("part_words", load_words, 1);
        fetch_one(8'h04);

        // Overflow: 65 words into 64
        fill_rand(260);
        run_load(1'b1, 1'b0);
        chk("ovf_err", load_err, 1);
        chk("ovf_words", load_words, 64);
        fetch_one(8'h00);
        chk("ovf_w0", fetch_instr, {q[3], q[2], q[1], q[0]});
        fetch_burst(30);

        // Reset in the middle of a load
        fill_rand(14);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        foreach (q[i]) begin
            load_byte_valid = 1'b1;
            load_byte       = q[i];
            step();
        end
        load_byte_valid = 1'b0;
        chk("mid_words", load_words, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_words", load_words, 0);
        chk("mid_rst_busy", load_busy, 1);
        chk("mid_rst_err", load_err, 0);
        step();
        rst_n = 1'b1;
        model_zero();
        wait_ready();
        chk("post_words", load_words, 0);
        fetch_burst(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
